// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle for param_sync_fifo: the master side drives requests and
// write data, the slave side (the FIFO) returns read data, flags and occupancy.
interface param_sync_fifo_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 9
);
   logic                w_inc;
   logic [DATASIZE-1:0] wdata;
   logic                r_inc;
   logic                err_clr;
   logic [DATASIZE-1:0] rdata;
   logic                wfull;
   logic                rempty;
   logic                almost_full;
   logic                almost_empty;
   logic [ADDRSIZE:0]   count;
   logic                overflow;
   logic                underflow;

   modport master (
      output w_inc, wdata, r_inc, err_clr,
      input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  w_inc, wdata, r_inc, err_clr,
      output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered occupancy/threshold flags,
// sticky overflow/underflow and an optional first-word-fall-through read port.
module param_sync_fifo #(
   parameter int DATASIZE      = 8,
   parameter int ADDRSIZE      = 9,
   parameter int AFULL_THRESH  = 2**ADDRSIZE - 4,
   parameter int AEMPTY_THRESH = 4,
   parameter int FWFT          = 0
) (
   input  logic               clk,
   input  logic               rst,
   param_sync_fifo_if.slave   f
);
   localparam int DEPTH = 2**ADDRSIZE;
   localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
   localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_THRESH);
   localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_THRESH);
   localparam logic [ADDRSIZE:0] PTR_ONE  = (ADDRSIZE+1)'(1);

   logic [DATASIZE-1:0] mem_q [DEPTH];

   logic [ADDRSIZE:0] wptr_q, wptr_d;
   logic [ADDRSIZE:0] rptr_q, rptr_d;
   logic [ADDRSIZE:0] count_q, count_d;
   logic              wfull_q, wfull_d;
   logic              rempty_q, rempty_d;
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_en, rd_en;

   logic [ADDRSIZE-1:0] waddr, raddr;
   assign waddr = wptr_q[ADDRSIZE-1:0];
   assign raddr = rptr_q[ADDRSIZE-1:0];

   // Acceptance uses this cycle's flags, so a same-edge pop never makes room for a push.
   assign wr_en = f.w_inc && !wfull_q;
   assign rd_en = f.r_inc && !rempty_q;

   always_comb begin
      wptr_d   = wr_en ? wptr_q + PTR_ONE : wptr_q;
      rptr_d   = rd_en ? rptr_q + PTR_ONE : rptr_q;
      count_d  = wptr_d - rptr_d;
      wfull_d  = (count_d == DEPTH_C);
      rempty_d = (count_d == '0);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
      ovf_d    = (ovf_q && !f.err_clr) || (f.w_inc && wfull_q);
      unf_d    = (unf_q && !f.err_clr) || (f.r_inc && rempty_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         wfull_q  <= 1'b0;
         rempty_q <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         wfull_q  <= wfull_d;
         rempty_q <= rempty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en && rst) begin
         mem_q[waddr] <= f.wdata;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign f.rdata = mem_q[raddr];
      end else begin : g_std
         logic [DATASIZE-1:0] rdata_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               rdata_q <= '0;
            end else if (rd_en) begin
               rdata_q <= mem_q[raddr];
            end
         end
         assign f.rdata = rdata_q;
      end
   endgenerate

   assign f.count        = count_q;
   assign f.wfull        = wfull_q;
   assign f.rempty       = rempty_q;
   assign f.almost_full  = afull_q;
   assign f.almost_empty = aempty_q;
   assign f.overflow     = ovf_q;
   assign f.underflow    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a standard-read and a FWFT instance of the FIFO with identical stimulus and
// checks both against a queue-based model every cycle, plus directed literal checks.
module tb_param_sync_fifo;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic w_inc = 1'b0, r_inc = 1'b0, err_clr = 1'b0;
   logic [DW-1:0] wdata = '0;

   int checks = 0;
   int failures = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   param_sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) fi0 ();
   param_sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) fi1 ();

   assign fi0.w_inc = w_inc;   assign fi1.w_inc = w_inc;
   assign fi0.wdata = wdata;   assign fi1.wdata = wdata;
   assign fi0.r_inc = r_inc;   assign fi1.r_inc = r_inc;
   assign fi0.err_clr = err_clr; assign fi1.err_clr = err_clr;

   param_sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .f(fi0.slave));
   param_sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(12),
                     .AEMPTY_THRESH(4), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .f(fi1.slave));

   // Behavioural model: a queue plus sticky bits and the last popped word.
   logic [DW-1:0] q[$];
   logic m_ovf = 1'b0, m_unf = 1'b0;
   logic [DW-1:0] m_rd0 = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rd0 = '0;
      end else begin
         bit full, empty;
         full  = (q.size() == DEPTH);
         empty = (q.size() == 0);
         m_ovf = (m_ovf && !err_clr) || (w_inc && full);
         m_unf = (m_unf && !err_clr) || (r_inc && empty);
         if (r_inc && !empty) m_rd0 = q.pop_front();
         if (w_inc && !full) q.push_back(wdata);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         int n;
         n = q.size();
         chk("count0", 32'(fi0.count), 32'(n));
         chk("count1", 32'(fi1.count), 32'(n));
         chk("rempty0", 32'(fi0.rempty), 32'(n == 0));
         chk("wfull0", 32'(fi0.wfull), 32'(n == DEPTH));
         chk("afull0", 32'(fi0.almost_full), 32'(n >= 12));
         chk("aempty0", 32'(fi0.almost_empty), 32'(n <= 4));
         chk("afull1", 32'(fi1.almost_full), 32'(n >= 12));
         chk("aempty1", 32'(fi1.almost_empty), 32'(n <= 4));
         chk("rempty1", 32'(fi1.rempty), 32'(n == 0));
         chk("wfull1", 32'(fi1.wfull), 32'(n == DEPTH));
         chk("ovf0", 32'(fi0.overflow), 32'(m_ovf));
         chk("unf0", 32'(fi0.underflow), 32'(m_unf));
         chk("ovf1", 32'(fi1.overflow), 32'(m_ovf));
         chk("unf1", 32'(fi1.underflow), 32'(m_unf));
         chk("rdata0", 32'(fi0.rdata), 32'(m_rd0));
         if (n != 0) chk("rdata1_head", 32'(fi1.rdata), 32'(q[0]));
      end
   end

   // Drive one cycle of requests, then return 1 time unit after the edge.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      w_inc = w; wdata = d; r_inc = r; err_clr = c;
      @(posedge clk);
      #1;
      w_inc = 1'b0; r_inc = 1'b0; err_clr = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(fi0.count), 32'd0);
      chk("rst_rempty", 32'(fi0.rempty), 32'd1);
      chk("rst_wfull", 32'(fi0.wfull), 32'd0);
      chk("rst_aempty", 32'(fi0.almost_empty), 32'd1);
      chk("rst_afull", 32'(fi0.almost_full), 32'd0);
      chk("rst_ovf", 32'(fi0.overflow), 32'd0);
      chk("rst_unf", 32'(fi0.underflow), 32'd0);
      chk("rst_rdata", 32'(fi0.rdata), 32'd0);
      rst = 1'b1;
      started = 1'b1;

      // Fill with 0x01..0x10, then read back in order.
      for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(fi0.count), 32'd16);
      chk("fill_wfull", 32'(fi0.wfull), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         chk("order_rdata", 32'(fi0.rdata), 32'(i));
      end
      chk("drained_rempty", 32'(fi0.rempty), 32'd1);

      // FWFT head visibility and threshold edges.
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("fwft_head", 32'(fi1.rdata), 32'h5A);
      for (int k = 2; k <= 16; k++) begin
         step(1'b1, DW'(k), 1'b0, 1'b0);
         if (k == 4)  chk("aempty_at4", 32'(fi1.almost_empty), 32'd1);
         if (k == 5)  chk("aempty_at5", 32'(fi1.almost_empty), 32'd0);
         if (k == 11) chk("afull_at11", 32'(fi1.almost_full), 32'd0);
         if (k == 12) chk("afull_at12", 32'(fi1.almost_full), 32'd1);
      end

      // Overflow while full, then clear.
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_set", 32'(fi0.overflow), 32'd1);
      chk("ovf_count", 32'(fi0.count), 32'd16);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("ovf_clr", 32'(fi0.overflow), 32'd0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("post_ovf_rd0", 32'(fi0.rdata), 32'h5A);
      chk("post_ovf_head1", 32'(fi1.rdata), 32'h02);
      drain();

      // Simultaneous request on empty: write wins, read flagged.
      step(1'b1, 8'h33, 1'b1, 1'b0);
      chk("unf_set", 32'(fi0.underflow), 32'd1);
      chk("unf_count", 32'(fi0.count), 32'd1);
      chk("unf_rempty", 32'(fi0.rempty), 32'd0);
      step(1'b0, '0, 1'b0, 1'b1);

      // Steady-state at 8 with pointer wrap.
      for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, DW'(8'h80 + i), 1'b1, 1'b0);
      chk("steady_count", 32'(fi0.count), 32'd8);

      // Random traffic with varying fill bias.
      for (int ph = 0; ph < 4; ph++) begin
         int pw, pr;
         pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
         pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
         for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < pw), DW'($urandom), 1'($urandom_range(0, 99) < pr),
                 1'($urandom_range(0, 99) < 5));
      end

      // Asynchronous reset mid-cycle at count 9.
      step(1'b0, '0, 1'b0, 1'b1);
      drain();
      for (int i = 0; i < 9; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
      chk("pre_rst_count", 32'(fi0.count), 32'd9);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_count", 32'(fi0.count), 32'd0);
      chk("arst_rempty", 32'(fi0.rempty), 32'd1);
      chk("arst_aempty", 32'(fi0.almost_empty), 32'd1);
      chk("arst_afull", 32'(fi0.almost_full), 32'd0);
      chk("arst_rdata", 32'(fi0.rdata), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b1, 8'h77, 1'b0, 1'b0);
      chk("post_rst_count", 32'(fi0.count), 32'd1);
      chk("post_rst_head1", 32'(fi1.rdata), 32'h77);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATASIZE, default 8: data word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 9: address width; DEPTH = 2**ADDRSIZE words; legal range 2..16.
REQ-003 SHALL have parameter AFULL_THRESH, default 2**ADDRSIZE-4: almost_full assertion level; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4: almost_empty assertion level; legal range 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-008 SHALL have port w_inc  input  1: write request.
REQ-009 SHALL have port wdata  input  DATASIZE: write data.
REQ-010 SHALL have port r_inc  input  1: read request (pop).
REQ-011 SHALL have port err_clr  input  1: synchronous clear of the sticky error flags.
REQ-012 SHALL have port rdata  output  DATASIZE: read data.
REQ-013 SHALL have port wfull / rempty  output  1 each: full / empty flags.
REQ-014 SHALL have port almost_full / almost_empty  output  1 each: threshold flags.
REQ-015 SHALL have port count  output  ADDRSIZE+1: current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow / underflow  output  1 each: sticky error flags.

Function
REQ-017 SHALL keep wptr and rptr at ADDRSIZE+1 bits each: the low ADDRSIZE bits address storage and the MSB is the wrap bit; waddr/raddr wrap from DEPTH-1 to 0.
REQ-018 SHALL accept a write iff w_inc && !wfull: mem[waddr] <= wdata and wptr increments.
REQ-019 SHALL accept a read iff r_inc && !rempty: rptr increments.
REQ-020 SHALL use flag values from the current cycle, so on a simultaneous request a write when full is rejected even if a read is accepted, and a read when empty is rejected even if a write is accepted.
REQ-021 SHALL register count, rempty, wfull, almost_full and almost_empty from next-state pointers, so each reflects the accepted operations of that edge with no extra lag.
REQ-022 SHALL define count = wptr - rptr modulo 2**(ADDRSIZE+1); rempty = (count==0); wfull = (count==DEPTH).
REQ-023 SHALL define almost_full = (count >= AFULL_THRESH) and almost_empty = (count <= AEMPTY_THRESH).
REQ-024 SHALL leave count unchanged and advance both pointers when a write and a read are both accepted on the same edge.
REQ-025 SHALL, with FWFT=0, load rdata <= mem[raddr] on an accepted read; data is visible one cycle after the r_inc edge and rdata holds its value otherwise.
REQ-026 SHALL, with FWFT=1, drive rdata = mem[raddr] combinationally; rdata is valid whenever rempty==0, r_inc pops the head, and the next word appears after that edge.
REQ-027 SHALL set overflow on any edge with w_inc && wfull and set underflow on any edge with r_inc && rempty; both hold until err_clr or reset.
REQ-028 SHALL give set priority over clear when err_clr and a new error occur on the same edge.
REQ-029 SHALL leave pointers, memory and count unmodified by rejected requests.

Reset
REQ-030 SHALL, while rst==0 and independent of clk, force wptr=rptr=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, overflow=underflow=0, and rdata=0 when FWFT=0.
REQ-031 SHALL NOT reset memory contents; when FWFT=1, rdata is don't-care while rempty==1.
REQ-032 SHALL, on reset asserted mid-operation, discard all contents; the first rising edge after rst returns to 1 operates normally. Release synchronisation is supplied externally.

Verification
REQ-033 SHALL cover: DATASIZE=8, ADDRSIZE=4, FWFT=0; write 0x01..0x10 -> wfull=1 and count=16 after the 16th edge; read 16 times -> rdata=0x01..0x10 in order, each one cycle after its r_inc; then rempty=1.
REQ-034 SHALL cover: FIFO full, then w_inc=1 with wdata=0xAA -> overflow=1, count stays 16, 0xAA is never read; assert err_clr for one cycle -> overflow=0.
REQ-035 SHALL cover: FIFO empty, then w_inc=1 and r_inc=1 on the same edge -> write accepted, underflow=1, count=1, rempty=0.
REQ-036 SHALL cover: count=8, then 20 cycles of simultaneous write and read -> count stays 8, pointers wrap past 15 to 0, and data order is preserved.
REQ-037 SHALL cover: FWFT=1 with AEMPTY_THRESH=4 and AFULL_THRESH=12; write 0x5A into an empty FIFO -> rdata=0x5A after that edge with no r_inc; almost_empty clears on the 5th entry and almost_full sets on the 12th.
REQ-038 SHALL cover: count=9, then pull rst low between clock edges -> all outputs take their reset values immediately; after release, one write makes count=1.
